// File: rtl/test_result_monitor_if.sv
// Harness-side link between the result monitor and one CI test module.
// Carries fail/finish in, the test reset out, and the verdict/status bus.
interface test_result_monitor_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 test_fail;
  logic                 test_finish;
  logic                 dut_reset;
  logic                 running;
  logic                 done;
  logic                 pass;
  logic                 failed;
  logic                 timed_out;
  logic [CNT_WIDTH-1:0] cycles;

  // harness / bench side: drives the test outputs, observes the verdict
  modport master (
    output test_fail,
    output test_finish,
    input  dut_reset,
    input  running,
    input  done,
    input  pass,
    input  failed,
    input  timed_out,
    input  cycles
  );

  // monitor side: consumes fail/finish, produces reset and verdict
  modport slave (
    input  test_fail,
    input  test_finish,
    output dut_reset,
    output running,
    output done,
    output pass,
    output failed,
    output timed_out,
    output cycles
  );
endinterface

// File: rtl/test_result_monitor.sv
// Test result monitor: generates the test module reset, runs a watchdog
// and latches one sticky verdict (PASS, FAIL or TIMEOUT).
//
// Ports:
//   clock  system clock, rising edge
//   reset  synchronous, active-high
//   bus    slave side of test_result_monitor_if
//          in : test_fail, test_finish
//          out: dut_reset, running, done, pass, failed, timed_out, cycles
//
// Optional macro TEST_RESULT_MONITOR_DISPLAY_EN: prints the verdict on the
// edge entering a terminal state and ends the simulation one cycle later.
// Port behaviour is identical with or without it.
module test_result_monitor #(
  parameter int RESET_CYCLES = 4,
  parameter int TIMEOUT      = 1000,
  parameter int CNT_WIDTH    = 32
) (
  input logic                  clock,
  input logic                  reset,
  test_result_monitor_if.slave bus
);

  typedef enum logic [2:0] {
    HOLD,
    RUN,
    PASS,
    FAIL,
    TOUT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TOUT_LAST = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_t               state;
  state_t               state_nx;
  logic [CNT_WIDTH-1:0] hold;
  logic [CNT_WIDTH-1:0] hold_nx;
  logic [CNT_WIDTH-1:0] cycles;
  logic [CNT_WIDTH-1:0] cycles_nx;
  logic                 dut_reset;
  logic                 dut_reset_nx;
  logic                 running;
  logic                 running_nx;
  logic                 done;
  logic                 done_nx;
  logic                 pass;
  logic                 pass_nx;
  logic                 failed;
  logic                 failed_nx;
  logic                 timed_out;
  logic                 timed_out_nx;

  logic fail_hit;
  logic finish_hit;
  logic tout_hit;

  // Anything other than a clean 0 on fail counts as a failure, and so does
  // an unknown finish; in synthesis these reduce to plain level tests.
  assign fail_hit = (bus.test_fail !== 1'b0) ||
                    ((bus.test_finish !== 1'b0) &&
                     (bus.test_finish !== 1'b1));
  assign finish_hit = (bus.test_finish === 1'b1);
  assign tout_hit   = (cycles == TOUT_LAST);

  always_comb begin
    state_nx     = state;
    hold_nx      = hold;
    cycles_nx    = cycles;
    dut_reset_nx = dut_reset;
    running_nx   = running;
    done_nx      = done;
    pass_nx      = pass;
    failed_nx    = failed;
    timed_out_nx = timed_out;

    unique case (state)
      HOLD: begin
        dut_reset_nx = 1'b1;
        hold_nx      = hold + CNT_ONE;
        if (hold == HOLD_LAST) begin
          state_nx     = RUN;
          hold_nx      = hold;
          dut_reset_nx = 1'b0;
          running_nx   = 1'b1;
        end
      end

      RUN: begin
        if (cycles != CNT_MAX) begin
          cycles_nx = cycles + CNT_ONE;
        end
        // fail beats finish, and both beat the watchdog limit
        if (fail_hit) begin
          state_nx   = FAIL;
          running_nx = 1'b0;
          done_nx    = 1'b1;
          failed_nx  = 1'b1;
        end else if (finish_hit) begin
          state_nx   = PASS;
          running_nx = 1'b0;
          done_nx    = 1'b1;
          pass_nx    = 1'b1;
        end else if (tout_hit) begin
          state_nx     = TOUT;
          running_nx   = 1'b0;
          done_nx      = 1'b1;
          timed_out_nx = 1'b1;
        end
      end

      PASS, FAIL, TOUT: begin
        // terminal: everything frozen until reset
      end

      default: begin
        state_nx = HOLD;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= HOLD;
      hold      <= '0;
      cycles    <= '0;
      dut_reset <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      failed    <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state     <= state_nx;
      hold      <= hold_nx;
      cycles    <= cycles_nx;
      dut_reset <= dut_reset_nx;
      running   <= running_nx;
      done      <= done_nx;
      pass      <= pass_nx;
      failed    <= failed_nx;
      timed_out <= timed_out_nx;
    end
  end

  assign bus.dut_reset = dut_reset;
  assign bus.running   = running;
  assign bus.done      = done;
  assign bus.pass      = pass;
  assign bus.failed    = failed;
  assign bus.timed_out = timed_out;
  assign bus.cycles    = cycles;

`ifdef TEST_RESULT_MONITOR_DISPLAY_EN
  logic finish_pend;

  always_ff @(posedge clock) begin
    if (reset) begin
      finish_pend <= 1'b0;
    end else begin
      if (finish_pend) begin
        $finish;
      end
      if (state == RUN && state_nx != RUN) begin
        if (state_nx == PASS) begin
          $display("[test_result_monitor] PASS cycles=%0d", cycles_nx);
        end else if (state_nx == FAIL) begin
          $display("[test_result_monitor] FAIL cycles=%0d", cycles_nx);
        end else begin
          $display("[test_result_monitor] TIMEOUT cycles=%0d", cycles_nx);
        end
        finish_pend <= 1'b1;
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_test_result_monitor.sv
// Self-checking bench for test_result_monitor: directed scenarios with
// literal expectations plus randomized runs against an event-level model.
module tb_test_result_monitor;

  localparam int R = 4;
  localparam int T = 8;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  test_result_monitor_if #(.CNT_WIDTH(W)) bus ();

  test_result_monitor #(
    .RESET_CYCLES(R),
    .TIMEOUT     (T),
    .CNT_WIDTH   (W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Model: k = edges since reset released; verdict 0 none, 1 pass,
  // 2 fail, 3 timeout; vcyc = RUN cycle number the verdict was taken on.
  int k       = 0;
  int verdict = 0;
  int vcyc    = 0;
  bit mvalid  = 1'b0;

  always @(posedge clock) begin : model
    int nv;
    int nc;
    int r;
    if (reset) begin
      k       <= 0;
      verdict <= 0;
      vcyc    <= 0;
      mvalid  <= 1'b1;
    end else begin
      nv = verdict;
      nc = vcyc;
      if (k >= R && verdict == 0) begin
        r = k - R + 1;
        if (bus.test_fail !== 1'b0) begin
          nv = 2;
          nc = r;
        end else if (bus.test_finish === 1'b1) begin
          nv = 1;
          nc = r;
        end else if (r == T) begin
          nv = 3;
          nc = r;
        end
      end
      verdict <= nv;
      vcyc    <= nc;
      if (k < 1000000) k <= k + 1;
    end
  end

  function automatic logic [5:0] exp_flags();
    return {k < R, (k >= R) && (verdict == 0), verdict != 0,
            verdict == 1, verdict == 2, verdict == 3};
  endfunction

  function automatic int exp_cycles();
    if (verdict != 0) return vcyc;
    if (k >= R) return k - R;
    return 0;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic logic [5:0] flags();
    return {bus.dut_reset, bus.running, bus.done,
            bus.pass, bus.failed, bus.timed_out};
  endfunction

  always @(negedge clock) begin
    if (mvalid) begin
      check("model_flags", 64'(flags()), 64'(exp_flags()));
      check("model_cycles", 64'(bus.cycles), 64'(exp_cycles()));
    end
  end

  task automatic drive(input bit f, input bit fin);
    bus.test_fail   = f;
    bus.test_finish = fin;
  endtask

  task automatic drive_rand();
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Called at a negedge; returns at the negedge where RUN cycle 1 inputs
  // are to be driven. Inputs are random during reset and HOLD.
  task automatic goto_run(input int rst_len);
    reset = 1'b1;
    repeat (rst_len) begin
      drive_rand();
      @(negedge clock);
    end
    reset = 1'b0;
    repeat (R) begin
      drive_rand();
      @(negedge clock);
    end
    drive(1'b0, 1'b0);
  endtask

  initial begin
    drive(1'b0, 1'b0);
    @(negedge clock);

    // reset sequence
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_flags", 64'(flags()), 64'(6'b100000));
    check("rst_cycles", 64'(bus.cycles), 64'd0);
    reset = 1'b0;
    repeat (R - 1) @(negedge clock);
    check("hold_last", 64'(bus.dut_reset), 64'd1);
    @(negedge clock);
    check("run_entry", 64'({bus.dut_reset, bus.running}), 64'(2'b01));

    // pass on first RUN cycle, finish held afterwards
    drive(1'b0, 1'b1);
    @(negedge clock);
    check("pass_flags", 64'(flags()), 64'(6'b001100));
    check("pass_cycles", 64'(bus.cycles), 64'd1);
    repeat (10) @(negedge clock);
    check("pass_frozen", 64'({bus.pass, bus.cycles}), {1'b1, 32'd1});
    drive(1'b0, 1'b0);

    // fail beats finish on RUN cycle 5
    goto_run(3);
    repeat (4) @(negedge clock);
    drive(1'b1, 1'b1);
    @(negedge clock);
    check("fail_flags", 64'(flags()), 64'(6'b001010));
    check("fail_cycles", 64'(bus.cycles), 64'd5);
    drive(1'b0, 1'b0);
    repeat (3) @(negedge clock);
    check("fail_sticky", 64'(flags()), 64'(6'b001010));

    // watchdog
    goto_run(3);
    repeat (T) @(negedge clock);
    check("tout_flags", 64'(flags()), 64'(6'b001001));
    check("tout_cycles", 64'(bus.cycles), 64'(T));

    // finish at the watchdog limit wins
    goto_run(3);
    repeat (T - 1) @(negedge clock);
    drive(1'b0, 1'b1);
    @(negedge clock);
    check("edge_flags", 64'(flags()), 64'(6'b001100));
    check("edge_cycles", 64'(bus.cycles), 64'(T));
    drive(1'b0, 1'b0);

    // reset mid-run
    goto_run(3);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_flags", 64'(flags()), 64'(6'b100000));
    check("midrst_cycles", 64'(bus.cycles), 64'd0);

    // reset after a pass, then a second run passes normally
    goto_run(2);
    drive(1'b0, 1'b1);
    @(negedge clock);
    drive(1'b1, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    check("postrst_flags", 64'(flags()), 64'(6'b100000));
    goto_run(2);
    @(negedge clock);
    drive(1'b0, 1'b1);
    @(negedge clock);
    check("rerun_flags", 64'(flags()), 64'(6'b001100));
    check("rerun_cycles", 64'(bus.cycles), 64'd2);
    drive(1'b0, 1'b0);

    // randomized runs
    for (int it = 0; it < 60; it++) begin
      goto_run(int'($urandom_range(1, 3)));
      for (int c = 0; c < T + 5; c++) begin
        drive($urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0);
        reset = ($urandom_range(0, 39) == 0);
        @(negedge clock);
      end
      reset = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
